// File: rtl/speech_sequencer.sv
// speech_sequencer
//   Queues spoken-word IDs and plays them one at a time through the audio controller.
//   Each ID maps to a flash byte range held in a writable 16-entry address table. After a word
//   completes, a programmable silence gap is inserted before the next word starts.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   push, push_id       enqueue a word ID
//   clear               flush queue, clear sticky flags, abort after the current word
//   tbl_we/idx/start/end  address-table write port (end address inclusive)
//   start_address, end_address, play_start  to audio controller
//   play_finish         from audio controller (high = idle)
//   full, empty         queue status (registered)
//   busy                sequencer not idle
//   done                one-cycle pulse after the last queued word and its gap
//   overflow, skipped   sticky: push dropped while full / word with end < start dropped
module speech_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 360000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [3:0]  push_id,
  input  logic        clear,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_idx,
  input  logic [23:0] tbl_start,
  input  logic [23:0] tbl_end,
  output logic [23:0] start_address,
  output logic [23:0] end_address,
  output logic        play_start,
  input  logic        play_finish,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        skipped
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
  // The PLAY cycle that first sees play_finish high counts as the first silent cycle, so the
  // next play_start rises GAP_CYCLES + 1 cycles after finish. A skipped word has no such
  // cycle and spends the whole gap in GAP. GAP always lasts at least one cycle.
  localparam logic [GapW-1:0] GapAfterPlay = (GAP_CYCLES >= 2) ? GapW'(GAP_CYCLES - 2) : '0;
  localparam logic [GapW-1:0] GapAfterSkip = (GAP_CYCLES >= 1) ? GapW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StPlay, StGap, StDrain} state_e;

  // Word queue
  logic [3:0]      queue_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q, overflow_q, overflow_d;
  logic            push_ok, pop;

  // Address table, {start, end} per entry
  logic [47:0]     tbl_q [16];
  logic [3:0]      head_id;
  logic [23:0]     head_start, head_end;

  // Sequencer
  state_e          state_q;
  logic [23:0]     start_addr_q, end_addr_q;
  logic            play_start_q, done_q, skipped_q, drain_acked_q;
  logic [GapW-1:0] gap_cnt_q;

  assign head_id    = queue_q[rd_ptr_q];
  assign head_start = tbl_q[head_id][47:24];
  assign head_end   = tbl_q[head_id][23:0];

  assign pop     = (state_q == StLoad) && !clear && !empty_q;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign push_ok = push && !clear && (!full_q || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_ok && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push_ok) count_d = count_q - CntW'(1);
      if (push && full_q && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CountFull);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) queue_q[wr_ptr_q] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[tbl_idx] <= {tbl_start, tbl_end};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      start_addr_q  <= '0;
      end_addr_q    <= '0;
      play_start_q  <= 1'b0;
      done_q        <= 1'b0;
      skipped_q     <= 1'b0;
      drain_acked_q <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) skipped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Looking at the incoming push lets a fresh word reach LOAD one cycle after push.
          if (play_finish && (!empty_q || push_ok)) state_q <= StLoad;
        end
        StLoad: begin
          if (clear || empty_q) begin
            state_q <= StIdle;
          end else if (head_end < head_start) begin
            skipped_q <= 1'b1;
            gap_cnt_q <= GapAfterSkip;
            state_q   <= StGap;
          end else begin
            start_addr_q <= head_start;
            end_addr_q   <= head_end;
            play_start_q <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          if (clear) begin
            play_start_q  <= 1'b0;
            drain_acked_q <= !play_finish;
            state_q       <= StDrain;
          end else if (!play_finish) begin
            play_start_q <= 1'b0;
            state_q      <= StPlay;
          end
        end
        StPlay: begin
          if (clear) begin
            drain_acked_q <= 1'b1;
            state_q       <= StDrain;
          end else if (play_finish) begin
            gap_cnt_q <= GapAfterPlay;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (clear) begin
            state_q <= StIdle;
          end else if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
          end else if (!empty_q) begin
            state_q <= StLoad;
          end else begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDrain: begin
          // An abort from START must first see the controller acknowledge the start.
          if (!drain_acked_q) begin
            if (!play_finish) drain_acked_q <= 1'b1;
          end else if (play_finish) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_address = start_addr_q;
  assign end_address   = end_addr_q;
  assign play_start    = play_start_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign skipped       = skipped_q;

endmodule

// File: tb/tb_speech_sequencer.sv
module tb_speech_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [3:0]  push_id;
  logic        clear;
  logic        tbl_we;
  logic [3:0]  tbl_idx;
  logic [23:0] tbl_start, tbl_end;
  logic [23:0] start_address, end_address;
  logic        play_start, play_finish;
  logic        full, empty, busy, done, overflow, skipped;

  speech_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .push(push), .push_id(push_id), .clear(clear),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_start(tbl_start), .tbl_end(tbl_end),
    .start_address(start_address), .end_address(end_address), .play_start(play_start),
    .play_finish(play_finish), .full(full), .empty(empty), .busy(busy), .done(done),
    .overflow(overflow), .skipped(skipped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference address table
  logic [23:0] ref_s [16];
  logic [23:0] ref_e [16];

  // Audio controller model
  int ack_delay = 2;
  int run_len   = 20;
  bit stall     = 0;
  int cph       = 0;
  int ccnt      = 0;

  // Event logs
  logic [23:0] ss_log [$];
  logic [23:0] se_log [$];
  int          st_cyc [$];
  int          fr_cyc [$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    play_finish = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        cph = 0;
        play_finish = 1'b1;
      end else if (stall) begin
        play_finish = 1'b0;
      end else begin
        case (cph)
          0: begin
            play_finish = 1'b1;
            if (play_start) begin
              cph = 1;
              ccnt = ack_delay;
            end
          end
          1: begin
            ccnt--;
            if (ccnt <= 0) begin
              play_finish = 1'b0;
              cph = 2;
              ccnt = run_len;
            end
          end
          default: begin
            ccnt--;
            if (ccnt <= 0) begin
              play_finish = 1'b1;
              cph = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    logic ps_prev;
    logic pf_prev;
    ps_prev = 1'b0;
    pf_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (play_start && !ps_prev) begin
          ss_log.push_back(start_address);
          se_log.push_back(end_address);
          st_cyc.push_back(cyc);
        end
        if (play_finish && !pf_prev) fr_cyc.push_back(cyc);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      ps_prev = play_start;
      pf_prev = play_finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ss_log.delete();
    se_log.delete();
    st_cyc.delete();
    fr_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; clear = 1'b0; tbl_we = 1'b0; stall = 0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_s[i] = '0;
      ref_e[i] = '0;
    end
  endtask

  task automatic write_tbl(input int idx, input logic [23:0] s, input logic [23:0] e);
    tbl_we = 1'b1; tbl_idx = idx[3:0]; tbl_start = s; tbl_end = e;
    tick();
    tbl_we = 1'b0;
    ref_s[idx] = s;
    ref_e[idx] = e;
  endtask

  task automatic write_valid(input int idx);
    logic [23:0] s;
    s = 24'($urandom_range(0, 24'h7FFFFF));
    write_tbl(idx, s, s + 24'($urandom_range(0, 24'h0FFFFF)));
  endtask

  task automatic push_word(input int id);
    push = 1'b1; push_id = id[3:0];
    tick();
    push = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_quiet(input int limit, output bit ok);
    int q;
    q = 0;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && empty && play_finish && !play_start && cph == 0) q++;
      else q = 0;
      if (q >= 3) begin
        ok = 1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    logic [54:0] exp_v;
    do_reset();
    @(negedge clk);
    exp_v = {24'h0, 24'h0, 7'b0010000};
    checks++;
    if ({start_address, end_address, play_start, full, empty, busy, done, overflow, skipped}
        !== exp_v) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h",
               {start_address, end_address, play_start, full, empty, busy, done, overflow,
                skipped}, exp_v);
    end
    tick();
  endtask

  task automatic test_first_word();
    bit ok;
    int diff;
    write_tbl(3, 24'h000100, 24'h0001FF);
    ack_delay = 2; run_len = 256;
    clear_logs();
    push_word(3);
    @(negedge clk);
    checks++;
    if ({empty, busy, play_start} !== 3'b010) begin
      errors++;
      $display("FAIL first_cycle1 empty/busy/start: got %b expected 010", {empty, busy, play_start});
    end
    @(negedge clk);
    checks++;
    if ({play_start, start_address, end_address} !== {1'b1, ref_s[3], ref_e[3]}) begin
      errors++;
      $display("FAIL first_cycle2 start/addr: got %h expected %h",
               {play_start, start_address, end_address}, {1'b1, ref_s[3], ref_e[3]});
    end
    tick();
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL first_timeout: got busy expected idle"); end
    checks++;
    if (ss_log.size() != 1) begin
      errors++;
      $display("FAIL first_start_count: got %0d expected 1", ss_log.size());
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL first_done_count: got %0d expected 1", done_cnt); end
    diff = (fr_cyc.size() > 0) ? done_cyc - fr_cyc[$] : -1;
    checks++;
    if (diff != GAP) begin errors++; $display("FAIL first_done_timing: got %0d expected %0d", diff, GAP); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ids [3];
    ids = '{1, 2, 1};
    write_valid(1);
    write_valid(2);
    ack_delay = 1; run_len = $urandom_range(8, 30);
    clear_logs();
    for (int k = 0; k < 3; k++) push_word(ids[k]);
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy expected idle"); end
    checks++;
    if (ss_log.size() != 3 || fr_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_counts: got %0d starts %0d finishes expected 3 3", ss_log.size(), fr_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({ss_log[k], se_log[k]} !== {ref_s[ids[k]], ref_e[ids[k]]}) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %h expected %h", k, {ss_log[k], se_log[k]},
                   {ref_s[ids[k]], ref_e[ids[k]]});
        end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (st_cyc[k] - fr_cyc[k-1] != GAP + 1) begin
          errors++;
          $display("FAIL b2b_interval[%0d]: got %0d expected %0d", k, st_cyc[k] - fr_cyc[k-1], GAP + 1);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    int ids [9];
    for (int i = 0; i < 16; i++) write_valid(i);
    ack_delay = 2; run_len = 12;
    stall = 1;
    tick();
    tick();
    clear_logs();
    for (int k = 0; k < 9; k++) ids[k] = $urandom_range(0, 15);
    for (int k = 0; k < 8; k++) push_word(ids[k]);
    @(negedge clk);
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_after8 full/overflow: got %b expected 10", {full, overflow});
    end
    tick();
    push_word(ids[8]);
    @(negedge clk);
    checks++;
    if ({full, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_after9 full/overflow: got %b expected 11", {full, overflow});
    end
    tick();
    stall = 0;
    wait_quiet(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout: got busy expected idle"); end
    checks++;
    if (ss_log.size() != 8) begin
      errors++;
      $display("FAIL ovf_start_count: got %0d expected 8", ss_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if ({ss_log[k], se_log[k]} !== {ref_s[ids[k]], ref_e[ids[k]]}) begin
          errors++;
          $display("FAIL ovf_order[%0d]: got %h expected %h", k, {ss_log[k], se_log[k]},
                   {ref_s[ids[k]], ref_e[ids[k]]});
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ovf_done_count: got %0d expected 1", done_cnt); end
    pulse_clear();
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    tick();
  endtask

  task automatic test_skip();
    bit ok;
    write_tbl(5, 24'h000010, 24'h00000F);
    write_valid(2);
    ack_delay = 2; run_len = 10;
    clear_logs();
    push_word(5);
    push_word(2);
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL skip_timeout: got busy expected idle"); end
    checks++;
    if (skipped !== 1'b1) begin errors++; $display("FAIL skip_flag: got %b expected 1", skipped); end
    checks++;
    if (ss_log.size() != 1) begin
      errors++;
      $display("FAIL skip_start_count: got %0d expected 1", ss_log.size());
    end else begin
      checks++;
      if (ss_log[0] !== ref_s[2]) begin
        errors++;
        $display("FAIL skip_played_addr: got %h expected %h", ss_log[0], ref_s[2]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL skip_done_count: got %0d expected 1", done_cnt); end
    pulse_clear();
    @(negedge clk);
    checks++;
    if (skipped !== 1'b0) begin errors++; $display("FAIL skip_clear: got %b expected 0", skipped); end
    tick();
  endtask

  task automatic test_clear();
    bit ok;
    bit found;
    write_valid(1);
    write_valid(2);
    write_valid(3);
    ack_delay = 2; run_len = 40;
    clear_logs();
    push_word(1);
    push_word(2);
    push_word(3);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy && !play_start && !play_finish) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL clear_reach_play: got no PLAY expected PLAY"); end
    tick();
    pulse_clear();
    @(negedge clk);
    checks++;
    if ({empty, busy} !== 2'b11) begin
      errors++;
      $display("FAIL clear_drain empty/busy: got %b expected 11", {empty, busy});
    end
    tick();
    wait_quiet(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_timeout: got busy expected idle"); end
    checks++;
    if (ss_log.size() != 1) begin
      errors++;
      $display("FAIL clear_start_count: got %0d expected 1", ss_log.size());
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL clear_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_reset_mid_start();
    bit ok;
    bit found;
    logic [54:0] exp_v;
    write_tbl(7, 24'h000300, 24'h000200);
    write_valid(4);
    ack_delay = 5; run_len = 20;
    clear_logs();
    push_word(4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (play_start) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach_start: got no start expected start"); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_s[i] = '0;
      ref_e[i] = '0;
    end
    @(negedge clk);
    exp_v = {24'h0, 24'h0, 7'b0010000};
    checks++;
    if ({start_address, end_address, play_start, full, empty, busy, done, overflow, skipped}
        !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_start: got %h expected %h",
               {start_address, end_address, play_start, full, empty, busy, done, overflow,
                skipped}, exp_v);
    end
    tick();
    clear_logs();
    ack_delay = 2;
    push_word(7);
    wait_quiet(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_timeout: got busy expected idle"); end
    checks++;
    if (skipped !== 1'b0) begin errors++; $display("FAIL rst_tbl_zero_skip: got %b expected 0", skipped); end
    checks++;
    if (ss_log.size() != 1) begin
      errors++;
      $display("FAIL rst_tbl_zero_count: got %0d expected 1", ss_log.size());
    end else begin
      checks++;
      if ({ss_log[0], se_log[0]} !== {ref_s[7], ref_e[7]}) begin
        errors++;
        $display("FAIL rst_tbl_zero_addr: got %h expected %h", {ss_log[0], se_log[0]},
                 {ref_s[7], ref_e[7]});
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    int ids [$];
    logic [47:0] exp_q [$];
    bit any_bad;
    logic [23:0] s;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) begin
        s = 24'($urandom_range(24'h000100, 24'hFF0000));
        if ($urandom_range(0, 3) == 0) write_tbl(i, s, s - 24'($urandom_range(1, 16)));
        else write_tbl(i, s, s + 24'($urandom_range(0, 65535)));
      end
      ack_delay = $urandom_range(1, 4);
      run_len = $urandom_range(4, 40);
      n = $urandom_range(3, 8);
      ids.delete();
      exp_q.delete();
      any_bad = 0;
      for (int k = 0; k < n; k++) begin
        ids.push_back($urandom_range(0, 15));
        if (ref_e[ids[k]] >= ref_s[ids[k]]) exp_q.push_back({ref_s[ids[k]], ref_e[ids[k]]});
        else any_bad = 1;
      end
      clear_logs();
      for (int k = 0; k < n; k++) push_word(ids[k]);
      wait_quiet(5000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got busy expected idle", it); end
      checks++;
      if (ss_log.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d expected %0d", it, ss_log.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if ({ss_log[k], se_log[k]} !== exp_q[k]) begin
            errors++;
            $display("FAIL rand%0d_word[%0d]: got %h expected %h", it, k, {ss_log[k], se_log[k]},
                     exp_q[k]);
          end
        end
      end
      checks++;
      if (skipped !== any_bad) begin
        errors++;
        $display("FAIL rand%0d_skipped: got %b expected %b", it, skipped, any_bad);
      end
      checks++;
      if (done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_done: got %0d expected 1", it, done_cnt);
      end
      pulse_clear();
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_id = '0; clear = 1'b0;
    tbl_we = 1'b0; tbl_idx = '0; tbl_start = '0; tbl_end = '0;
    test_reset();
    test_first_word();
    test_back_to_back();
    test_overflow();
    test_skip();
    test_clear();
    test_reset_mid_start();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
